// File: rtl/gru_seq_ctrl.sv
// rtl/gru_seq_ctrl.sv - GRU input/hidden-state sequencer with x_t prefetch FIFO; GRU_HSEQ_EN emits every step's h_t
module gru_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int H          = 4,
  parameter int X          = 4,
  parameter int SEQ_LEN    = 8,
  parameter int CELL_LAT   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    seq_start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [X*DATA_WIDTH-1:0] x_in,
  output logic [X*DATA_WIDTH-1:0] x_cell,
  output logic [H*DATA_WIDTH-1:0] h_cell,
  input  logic [H*DATA_WIDTH-1:0] h_from_cell,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [H*DATA_WIDTH-1:0] h_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SEQ_LEN + 1);
  localparam int CW = $clog2(CELL_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_DONE
`ifdef GRU_HSEQ_EN
    , S_HOLD
`endif
  } state_t;

  state_t                  state;
  logic [SW-1:0]           step;
  logic [CW-1:0]           wait_cnt;

  logic [X*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = (state == S_LOAD) && !fifo_empty;
  // A pop frees the head slot this very cycle, so a full FIFO can still take
  // a word alongside it; in_ready only advertises the registered occupancy.
  assign push       = in_valid && (!fifo_full || pop);
  assign in_ready   = !fifo_full;
  assign busy       = (state != S_IDLE);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk1) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= x_in;
    end
  end

  // FIFO pointers, wrapping naturally modulo 2*FIFO_DEPTH.
  always_ff @(posedge clk1) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sequencer FSM: load x_t, hold cell inputs for CELL_LAT cycles, capture H_t, repeat.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= '0;
      wait_cnt  <= '0;
      x_cell    <= '0;
      h_cell    <= '0;
      h_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (seq_start) begin
            h_cell <= '0;
            step   <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!fifo_empty) begin
            x_cell   <= mem[rd_ptr[AW-1:0]];
            wait_cnt <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (wait_cnt == CW'(CELL_LAT - 1)) begin
            state <= S_CAPT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CAPT: begin
          h_cell <= h_from_cell;
          step   <= step + 1'b1;
          if (step == SW'(SEQ_LEN - 1)) begin
            h_out     <= h_from_cell;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
`ifdef GRU_HSEQ_EN
            h_out     <= h_from_cell;
            out_valid <= 1'b1;
            state     <= S_HOLD;
`else
            state     <= S_LOAD;
`endif
          end
        end
`ifdef GRU_HSEQ_EN
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_LOAD;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// tb/tb_gru_seq_ctrl.sv - self-checking bench for gru_seq_ctrl with a stub h+x cell
module tb_gru_seq_ctrl;
  localparam int DW         = 8;
  localparam int H          = 4;
  localparam int X          = 4;
  localparam int SEQ_LEN    = 8;
  localparam int CELL_LAT   = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int VW         = X * DW;
`ifdef GRU_HSEQ_EN
  localparam int FIRST_LAT  = CELL_LAT + 2;
`else
  localparam int FIRST_LAT  = SEQ_LEN * (CELL_LAT + 2);
`endif

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          seq_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] x_in = '0;
  logic          in_ready;
  logic          busy;
  logic          out_valid;
  logic [VW-1:0] x_cell;
  logic [H*DW-1:0] h_cell;
  logic [H*DW-1:0] h_from_cell;
  logic [H*DW-1:0] h_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int lat = 0;
  bit mon_done = 0;
  int xch = 0;
  int hch = 0;
  logic [VW-1:0] xq[$];
  logic [VW-1:0] v;
  logic [VW-1:0] prev_x;
  logic [H*DW-1:0] prev_h;

  gru_seq_ctrl #(
    .DATA_WIDTH(DW), .H(H), .X(X), .SEQ_LEN(SEQ_LEN),
    .CELL_LAT(CELL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk1(clk1), .rst(rst), .seq_start(seq_start),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .x_cell(x_cell), .h_cell(h_cell), .h_from_cell(h_from_cell),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .h_out(h_out)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  // Stub cell: H_t = h_(t-1) + x_t elementwise, wrapping at DW bits.
  always_comb begin
    h_from_cell = '0;
    for (int i = 0; i < H; i++)
      h_from_cell[i*DW +: DW] = h_cell[i*DW +: DW] + x_cell[i*DW +: DW];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < X; i++) r[i*DW +: DW] = DW'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic logic [VW-1:0] ones_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < X; i++) r[i*DW +: DW] = DW'(1);
    return r;
  endfunction

  // Reference: the hidden state after step s is the elementwise sum of x_0..x_s.
  function automatic logic [H*DW-1:0] exp_h(input int s);
    logic [H*DW-1:0] acc;
    acc = '0;
    for (int k = 0; k <= s; k++) begin
      if (k < xq.size()) begin
        for (int i = 0; i < H; i++)
          acc[i*DW +: DW] = acc[i*DW +: DW] + xq[k][i*DW +: DW];
      end
    end
    return acc;
  endfunction

  task automatic reset_dut();
    @(negedge clk1);
    rst = 1'b1; in_valid = 1'b0; seq_start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    xq.delete();
  endtask

  // Source honouring in_ready; gap<0 selects a random 0..3 idle gap per word.
  task automatic push_vecs(input int n, input int gap, input bit rnd);
    int sent;
    int waited;
    int idle;
    int cur_gap;
    logic [VW-1:0] d;
    sent = 0; waited = 0; idle = 0;
    cur_gap = (gap < 0) ? $urandom_range(0, 3) : gap;
    while (sent < n && waited < 5000) begin
      @(negedge clk1);
      waited++;
      if (in_ready && idle >= cur_gap) begin
        d = rnd ? rand_vec() : ones_vec();
        x_in = d; in_valid = 1'b1;
        xq.push_back(d);
        sent++; idle = 0;
        cur_gap = (gap < 0) ? $urandom_range(0, 3) : gap;
      end else begin
        in_valid = 1'b0;
        idle++;
      end
    end
    @(negedge clk1);
    in_valid = 1'b0;
    chk("push_count", sent, n);
  endtask

  task automatic start_seq();
    @(negedge clk1);
    seq_start = 1'b1;
    @(negedge clk1);
    seq_start = 1'b0;
    t0 = cyc;
  endtask

  // Sink: waits for each emitted h_t, holds off for a while, then accepts it.
  task automatic recv_seq(input int final_stall, input bit poke, output int first_lat);
    int n;
    int stall;
    bit ok;
    logic [H*DW-1:0] e;
    first_lat = -1;
    for (int s = 0; s < SEQ_LEN; s++) begin
`ifndef GRU_HSEQ_EN
      if (s != SEQ_LEN - 1) continue;
`endif
      n = 0;
      @(negedge clk1);
      while (!out_valid && n < 4000) begin
        @(negedge clk1);
        n++;
      end
      chk("out_valid_seen", out_valid, 1'b1);
      if (out_valid !== 1'b1) return;
      if (first_lat < 0) first_lat = cyc - t0;
      e = exp_h(s);
      chk("h_out_value", h_out, e);
      stall = (s == SEQ_LEN - 1) ? final_stall : $urandom_range(0, 2);
      ok = 1'b1;
      for (int k = 0; k < stall; k++) begin
        seq_start = (poke && (k == 3 || k == 7)) ? 1'b1 : 1'b0;
        @(negedge clk1);
        if (!(out_valid === 1'b1 && h_out === e)) ok = 1'b0;
      end
      seq_start = 1'b0;
      if (stall > 0) chk("hold_stable", ok, 1'b1);
      out_ready = 1'b1;
      @(negedge clk1);
      out_ready = 1'b0;
      chk("valid_drop", out_valid, 1'b0);
    end
    chk("idle_after_accept", busy, 1'b0);
    for (int k = 0; k < SEQ_LEN; k++) if (xq.size() > 0) xq.delete(0);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk1);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_h_cell", h_cell, '0);
    chk("rst_x_cell", x_cell, '0);
    chk("rst_h_out", h_out, '0);

    // test 1: reset mid-RUN aborts and drops buffered data
    push_vecs(4, 0, 0);
    start_seq();
    repeat (20) @(negedge clk1);
    chk("t1_busy_mid", busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    xq.delete();
    chk("t1_out_valid", out_valid, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_in_ready", in_ready, 1'b1);
    chk("t1_h_cell", h_cell, '0);
    chk("t1_x_cell", x_cell, '0);
    start_seq();
    repeat (30) @(negedge clk1);
    chk("t1_fifo_empty_stall_busy", busy, 1'b1);
    chk("t1_fifo_empty_stall_x", x_cell, '0);
    reset_dut();

    // test 2: nominal all-ones sequence
    push_vecs(4, 0, 0);
    fork
      begin start_seq(); recv_seq(0, 0, lat); end
      push_vecs(4, 0, 0);
    join
    chk("t2_latency", lat, FIRST_LAT);
    chk("t2_h_out_eight", h_out, {H{8'd8}});

    // test 3: full FIFO with simultaneous push and pop
    reset_dut();
    push_vecs(4, 0, 1);
    chk("t3_full_in_ready", in_ready, 1'b0);
    @(negedge clk1);
    seq_start = 1'b1;
    @(negedge clk1);
    seq_start = 1'b0;
    t0 = cyc;
    v = rand_vec();
    x_in = v; in_valid = 1'b1;
    xq.push_back(v);
    chk("t3_load_in_ready", in_ready, 1'b0);
    @(negedge clk1);
    in_valid = 1'b0;
    chk("t3_occupancy_kept", in_ready, 1'b0);
    chk("t3_first_pop", x_cell, xq[0]);
    fork
      push_vecs(3, 0, 1);
      recv_seq(0, 0, lat);
      begin
        prev_x = x_cell;
        for (int k = 1; k < SEQ_LEN; k++) begin
          int n;
          n = 0;
          while (x_cell === prev_x && n < 400) begin
            @(negedge clk1);
            n++;
          end
          chk("t3_order", x_cell, (k < xq.size()) ? xq[k] : '0);
          prev_x = x_cell;
        end
      end
    join

    // test 4: starvation, one x_t every 20 cycles
    reset_dut();
    mon_done = 0; xch = 0; hch = 0;
    fork
      begin start_seq(); recv_seq(0, 0, lat); mon_done = 1; end
      push_vecs(8, 20, 0);
      begin
        prev_x = x_cell; prev_h = h_cell;
        while (!mon_done) begin
          @(negedge clk1);
          if (x_cell !== prev_x) xch++;
          if (h_cell !== prev_h) hch++;
          prev_x = x_cell; prev_h = h_cell;
        end
      end
    join
    chk("t4_x_changes", xch, 1);
    chk("t4_h_changes", hch, SEQ_LEN);
    chk("t4_stalled_latency", lat > FIRST_LAT, 1'b1);
    chk("t4_h_out_eight", h_out, {H{8'd8}});

    // test 5: output backpressure with ignored seq_start pulses
    reset_dut();
    push_vecs(4, 0, 0);
    fork
      begin start_seq(); recv_seq(10, 1, lat); end
      push_vecs(4, 0, 0);
    join
    repeat (3) @(negedge clk1);
    chk("t5_still_idle", busy, 1'b0);
    chk("t5_h_out_kept", h_out, {H{8'd8}});

    // randomized back-to-back sequences with prefetch across boundaries
    for (int r = 0; r < 3; r++) begin
      push_vecs(4, 0, 1);
      fork
        begin start_seq(); recv_seq($urandom_range(0, 5), 0, lat); end
        push_vecs(4, -1, 1);
      join
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
